// File: rtl/readback_pkg.sv
// Shared definitions for the multibit readback serializer:
// word/field widths, frame word count helper and the FSM state type.
package readback_pkg;

  localparam int WORD_W = 16;
  localparam int DATA_W = 24;
  localparam int TS_W   = 32;

  // Number of 16-bit words needed to carry the state word plus the data word.
  function automatic int calc_nw(input int bits);
    return (bits + DATA_W + WORD_W - 1) / WORD_W;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/snapshot_fifo.sv
// Register FIFO of WIDTH-bit snapshots, DEPTH entries (power of two).
// Exposes the head entry and the entry behind it so the reader can start
// the next frame in the same cycle it retires the current one.
module snapshot_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] fill_o,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] head_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign full_o      = (fill_q == CNT_W'(DEPTH));
  assign empty_o     = (fill_q == '0);
  assign fill_o      = fill_q;
  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_q + PTR_W'(1)];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    fill_d = fill_q;
    case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q <= fill_d;
    end
  end

  // Storage array; contents are qualified by fill, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/multibit_readback_serializer.sv
// Readback end of the multibit set/capture path. Snapshots {data_in, state_in}
// into a FIFO on capture and streams each snapshot as a fixed-length frame of
// 16-bit words, LSW first, under valid/ready.
// Optional feature macro: READBACK_TIMESTAMP_EN appends a 32-bit capture-time
// stamp as two extra words per frame.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | nothing to send, out_valid low; leaves as soon as an entry exists
//   SEND  | out_data holds word idx of the head entry; advances on handshake
module multibit_readback_serializer
  import readback_pkg::*;
#(
  parameter int BITS  = 38,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     capture,
  input  logic [BITS-1:0]          state_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic                     overflow_clear
);

  localparam int NW = calc_nw(BITS);
`ifdef READBACK_TIMESTAMP_EN
  localparam int FL = NW + 2;
  localparam int EW = NW * WORD_W + TS_W;
`else
  localparam int FL = NW;
  localparam int EW = NW * WORD_W;
`endif
  localparam int IDX_W = $clog2(FL);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_nxt;
  logic                out_valid_q;
  logic [WORD_W-1:0]   out_data_q;
  logic                out_last_q;
  logic                overflow_q;
  logic                overflow_d;

  logic [EW-1:0]       entry_in;
  logic [EW-1:0]       head;
  logic [EW-1:0]       head_next;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_fill;

  logic                hs;
  logic                pop;
  logic                push;
  logic                drop;

  function automatic logic [WORD_W-1:0] word_of(input logic [EW-1:0] e,
                                                input logic [IDX_W-1:0] k);
    return e[int'(k) * WORD_W +: WORD_W];
  endfunction

`ifdef READBACK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running capture timestamp, wraps at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + TS_W'(1);
  end
`endif

  // Pack the incoming snapshot: state in the low bits, data above, zero pad,
  // optional timestamp after the last data word.
  always_comb begin
    entry_in = '0;
    entry_in[BITS-1:0]       = state_in;
    entry_in[BITS +: DATA_W] = data_in;
`ifdef READBACK_TIMESTAMP_EN
    entry_in[NW*WORD_W +: TS_W] = ts_q;
`endif
  end

  assign hs      = out_valid_q && out_ready;
  assign pop     = hs && out_last_q;
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;
  assign idx_nxt = idx_q + IDX_W'(1);

  snapshot_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (push),
    .wdata_i     (entry_in),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .fill_o      (fifo_fill),
    .head_o      (head),
    .head_next_o (head_next)
  );

  // Frame sequencer with registered outputs. A capture into an empty FIFO is
  // forwarded straight into the output register so the first word appears the
  // cycle after the strobe; likewise when the last queued frame retires in the
  // same cycle a new snapshot arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= SEND;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= word_of(head, '0);
            out_last_q  <= 1'b0;
          end else if (push) begin
            state_q     <= SEND;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= word_of(entry_in, '0);
            out_last_q  <= 1'b0;
          end
        end
        SEND: begin
          if (hs) begin
            if (!out_last_q) begin
              idx_q      <= idx_nxt;
              out_data_q <= word_of(head, idx_nxt);
              out_last_q <= (idx_nxt == IDX_W'(FL - 1));
            end else begin
              idx_q      <= '0;
              out_last_q <= 1'b0;
              if (fifo_fill > CNT_W'(1)) begin
                out_data_q <= word_of(head_next, '0);
              end else if (push) begin
                out_data_q <= word_of(entry_in, '0);
              end else begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
              end
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Clear has priority over a drop landing in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clear) overflow_d = 1'b0;
    else if (drop)      overflow_d = 1'b1;
  end

  // Sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign fill      = fifo_fill;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_multibit_readback_serializer.sv
// Self-checking bench for multibit_readback_serializer (BITS=38, DEPTH=4).
// A queue-based model tracks the snapshots held and the word in flight;
// a compare process checks every output on every falling edge.
module tb_multibit_readback_serializer;

  localparam int BITS  = 38;
  localparam int DEPTH = 4;
  localparam int NW    = 4;
`ifdef READBACK_TIMESTAMP_EN
  localparam int FL = NW + 2;
  localparam logic [127:0] TS_MASK = {64'h0, 32'hFFFF_FFFF, 32'h0} << 32;
`else
  localparam int FL = NW;
  localparam logic [127:0] TS_MASK = '0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              capture = 1'b0;
  logic [BITS-1:0]   state_in = '0;
  logic [23:0]       data_in = '0;
  logic              out_ready = 1'b0;
  logic              overflow_clear = 1'b0;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_last;
  logic [2:0]        fill;
  logic              overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int dut_hs   = 0;

  always #5 clock = ~clock;

  multibit_readback_serializer #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .capture        (capture),
    .state_in       (state_in),
    .data_in        (data_in),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .fill           (fill),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [127:0] mq[$];
  int           m_idx = 0;
  logic         m_ovf = 1'b0;
  logic [31:0]  m_ts  = '0;

  function automatic logic [127:0] make_entry(input logic [BITS-1:0] s, input logic [23:0] d,
                                              input logic [31:0] ts);
    logic [127:0] e;
    e = (128'(d) << BITS) | 128'(s);
    e = e | ((128'(ts) << (NW * 16)) & TS_MASK);
    return e;
  endfunction

  function automatic logic [15:0] word_at(input logic [127:0] e, input int k);
    return e[k*16 +: 16];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_idx = 0;
      m_ovf = 1'b0;
      m_ts  = '0;
    end else begin
      bit hs_m, pop_m, drop_m;
      hs_m   = (mq.size() != 0) && out_ready;
      pop_m  = hs_m && (m_idx == FL - 1);
      drop_m = 1'b0;
      if (hs_m) m_idx = pop_m ? 0 : m_idx + 1;
      if (capture) begin
        if (mq.size() < DEPTH || pop_m) mq.push_back(make_entry(state_in, data_in, m_ts));
        else drop_m = 1'b1;
      end
      if (pop_m) void'(mq.pop_front());
      if (overflow_clear) m_ovf = 1'b0;
      else if (drop_m)    m_ovf = 1'b1;
      m_ts = m_ts + 32'd1;
    end
  end

  // Every cycle: occupancy, flag, valid and (when valid) the word and last marker.
  always @(negedge clock) begin
    check("fill", 64'(fill), 64'(mq.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("out_data", 64'(out_data), 64'(word_at(mq[0], m_idx)));
      check("out_last", 64'(out_last), 64'(m_idx == FL - 1));
    end
    if (out_valid && out_ready) dut_hs++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cap(input logic [BITS-1:0] s, input logic [23:0] d);
    state_in = s;
    data_in  = d;
    capture  = 1'b1;
    step();
    capture  = 1'b0;
  endtask

  logic [15:0] w [32];
  logic        l [32];
  logic [6:0]  pat;
  int          hs0;

  initial begin
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    step();

`ifdef READBACK_TIMESTAMP_EN
    for (int i = 0; i < 100 && m_ts != 32'h10; i++) step();
    check("ts_reach", 64'(m_ts), 64'h10);
    out_ready = 1'b1;
    cap(38'h1, 24'h2);
    for (int k = 0; k < 6; k++) begin
      w[k] = out_data;
      l[k] = out_last;
      step();
    end
    check("ts_word5", 64'(w[4]), 64'h0010);
    check("ts_word6", 64'(w[5]), 64'h0000);
    check("ts_last5", 64'(l[4]), 64'd0);
    check("ts_last6", 64'(l[5]), 64'd1);
    out_ready = 1'b0;
`endif

    // Single frame. E = {pad, data[23:0], state[37:0]}:
    // E[15:0]=BEEF, E[31:16]=DEAD, E[47:32]={data[9:0],state[37:32]}=15AA,
    // E[63:48]={2'b0,data[23:10]}=048D.
    out_ready = 1'b1;
    cap(38'h2A_DEAD_BEEF, 24'h123456);
    check("sf_valid_1cyc", 64'(out_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      w[k] = out_data;
      l[k] = out_last;
      step();
    end
    check("sf_w0", 64'(w[0]), 64'hBEEF);
    check("sf_w1", 64'(w[1]), 64'hDEAD);
    check("sf_w2", 64'(w[2]), 64'h15AA);
    check("sf_w3", 64'(w[3]), 64'h048D);
    check("sf_last", 64'({l[3], l[2], l[1], l[0]}), 64'b1000);
    check("sf_idle", 64'(out_valid), 64'd0);

    // Backpressure 1,0,0,1,1,0,1 -> four handshakes.
    out_ready = 1'b0;
    cap(38'h2A_DEAD_BEEF, 24'h123456);
    hs0 = dut_hs;
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      if (i == 6) check("bp_fill_before_last", 64'(fill), 64'd1);
      step();
    end
    out_ready = 1'b0;
    check("bp_handshakes", 64'(dut_hs - hs0), 64'd4);
    check("bp_fill_after", 64'(fill), 64'd0);

    // Full / overflow.
    for (int v = 1; v <= 5; v++) cap(BITS'(v), 24'(v));
    check("full_fill", 64'(fill), 64'd4);
    check("full_ovf", 64'(overflow), 64'd1);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w[i] = out_data;
      step();
    end
    for (int f = 0; f < 4; f++) begin
      check("full_frame_w0", 64'(w[4*f]), 64'(f + 1));
      check("full_frame_w2", 64'(w[4*f+2]), 64'((f + 1) << 6));
    end
    check("full_no_fifth", 64'(out_valid), 64'd0);

    // Capture coinciding with the final-word handshake of a full FIFO.
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) cap(BITS'(v + 16), 24'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !out_last; i++) step();
    check("same_wait_last", 64'(out_last), 64'd1);
    check("same_pre_fill", 64'(fill), 64'd4);
    cap(BITS'(38'h99), 24'h0);
    check("same_fill", 64'(fill), 64'd4);
    check("same_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) begin
      w[i] = out_data;
      step();
    end
    check("same_next_frame", 64'(w[0]), 64'h12);
    check("same_new_last", 64'(w[12]), 64'h99);

    // Reset after two words of a frame.
    out_ready = 1'b0;
    cap(BITS'(38'h77), 24'h5);
    out_ready = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("rmid_valid", 64'(out_valid), 64'd0);
    check("rmid_fill", 64'(fill), 64'd0);
    check("rmid_last", 64'(out_last), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cap(BITS'(38'h3C), 24'h0);
    check("rmid_new_valid", 64'(out_valid), 64'd1);
    check("rmid_new_w0", 64'(out_data), 64'h003C);
    for (int i = 0; i < FL; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      capture        = ($urandom_range(9) < 3);
      state_in       = BITS'({$urandom(), $urandom()});
      data_in        = 24'($urandom());
      out_ready      = ($urandom_range(9) < 6);
      overflow_clear = ($urandom_range(19) == 0);
      step();
    end
    capture        = 1'b0;
    overflow_clear = 1'b0;
    out_ready      = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("drain_empty", 64'(fill), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
